// File: rtl/cond_flag_pkg.sv
// rtl/cond_flag_pkg.sv - shared constants and types for the NZCV flag / condition unit
package cond_flag_pkg;

  // NZCV vector, bit order [3]=N [2]=Z [1]=C [0]=V
  typedef logic [3:0] nzcv_t;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// rtl/cond_flag_unit_cond_eval.sv - combinational ARM-style condition code evaluator
module cond_eval
  import cond_flag_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLG_N];
  assign z = flags[FLG_Z];
  assign c = flags[FLG_C];
  assign v = flags[FLG_V];

  // Decode the condition field against the supplied flags
  always_comb begin
    pass = 1'b0;
    case (cond_code)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register, shadow copy, condition evaluation and squash counter
module cond_flag_unit
  import cond_flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic             upd_s,
  input  logic [3:0]       new_flag,
  output logic [3:0]       flag_out,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             res_valid,
  output logic             res_pass,
  input  logic             res_ready,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [3:0]       shadow_out
);

  nzcv_t flag_q;
  nzcv_t shadow_q;
  nzcv_t eff;
  logic  pass;
  logic  accept;

  // Effective flags: restore beats a retiring update, which beats the held value
  always_comb begin
    eff = flag_q;
    if (restore_req) begin
      eff = shadow_q;
    end else if (upd_valid && upd_s) begin
      eff = new_flag;
    end
  end

  cond_eval u_cond_eval (
    .cond_code (cond_code),
    .flags     (eff),
    .pass      (pass)
  );

  assign cond_ready = !res_valid || res_ready;
  assign accept     = cond_valid && cond_ready;

  // Architectural flags follow the effective value every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else begin
      flag_q <= eff;
    end
  end

  // Shadow capture; a simultaneous restore leaves the shadow untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (save_req && !restore_req) begin
      shadow_q <= eff;
    end
  end

  // One-entry result register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_pass  <= pass;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating count of squashed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt <= '0;
    end else if (accept && !pass && (squash_cnt != {CNT_W{1'b1}})) begin
      squash_cnt <= squash_cnt + 1'b1;
    end
  end

  assign flag_out   = flag_q;
  assign shadow_out = shadow_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - directed self-checking bench for cond_flag_unit
module tb_cond_flag_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             upd_valid;
  logic             upd_s;
  logic [3:0]       new_flag;
  logic [3:0]       flag_out;
  logic             save_req;
  logic             restore_req;
  logic             cond_valid;
  logic [3:0]       cond_code;
  logic             cond_ready;
  logic             res_valid;
  logic             res_pass;
  logic             res_ready;
  logic [CNT_W-1:0] squash_cnt;
  logic [3:0]       shadow_out;

  int total;
  int bad;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_valid   (upd_valid),
    .upd_s       (upd_s),
    .new_flag    (new_flag),
    .flag_out    (flag_out),
    .save_req    (save_req),
    .restore_req (restore_req),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .res_valid   (res_valid),
    .res_pass    (res_pass),
    .res_ready   (res_ready),
    .squash_cnt  (squash_cnt),
    .shadow_out  (shadow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    upd_valid = 1'b1;
    upd_s     = 1'b1;
    new_flag  = f;
    tick();
    upd_valid = 1'b0;
    upd_s     = 1'b0;
  endtask

  task automatic issue(input logic [3:0] code);
    cond_valid = 1'b1;
    cond_code  = code;
    tick();
    cond_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    upd_valid = 1'b0; upd_s = 1'b0; new_flag = 4'h0;
    save_req = 1'b0; restore_req = 1'b0;
    cond_valid = 1'b0; cond_code = 4'h0; res_ready = 1'b1;

    tick();
    chk("rst_flag", flag_out, 4'h0);
    chk("rst_cnt", squash_cnt, 0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_shadow", shadow_out, 4'h0);
    rst_n = 1'b1;
    tick();

    issue(4'h0);
    chk("eq_valid", res_valid, 1'b1);
    chk("eq_zero", res_pass, 1'b0);
    chk("eq_cnt", squash_cnt, 1);
    issue(4'hE);
    chk("al_pass", res_pass, 1'b1);
    tick();
    chk("idle_valid", res_valid, 1'b0);

    // Bypass: update and request in the same cycle
    upd_valid = 1'b1; upd_s = 1'b1; new_flag = 4'b0100;
    issue(4'h0);
    upd_valid = 1'b0; upd_s = 1'b0;
    chk("byp_pass", res_pass, 1'b1);
    chk("byp_flag", flag_out, 4'b0100);
    set_flags(4'b0000);
    upd_valid = 1'b1; upd_s = 1'b0; new_flag = 4'b0100;
    issue(4'h0);
    upd_valid = 1'b0;
    chk("nos_pass", res_pass, 1'b0);
    chk("nos_flag", flag_out, 4'b0000);

    // Signed and unsigned compares
    set_flags(4'b1000);
    issue(4'hA); chk("ge_nv", res_pass, 1'b0);
    issue(4'hB); chk("lt_nv", res_pass, 1'b1);
    issue(4'hC); chk("gt_nv", res_pass, 1'b0);
    issue(4'hD); chk("le_nv", res_pass, 1'b1);
    set_flags(4'b0010);
    issue(4'h8); chk("hi_c", res_pass, 1'b1);
    set_flags(4'b0110);
    issue(4'h8); chk("hi_cz", res_pass, 1'b0);
    issue(4'h9); chk("ls_cz", res_pass, 1'b1);

    // Backpressure
    set_flags(4'b0000);
    res_ready = 1'b0;
    issue(4'hC);
    chk("bp_valid0", res_valid, 1'b1);
    chk("bp_pass0", res_pass, 1'b1);
    cond_valid = 1'b1; cond_code = 4'hF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_lo", cond_ready, 1'b0);
      tick();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_pass", res_pass, 1'b1);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_hi", cond_ready, 1'b1);
    tick();
    cond_valid = 1'b0;
    chk("bp2_valid", res_valid, 1'b1);
    chk("bp2_pass", res_pass, 1'b0);
    tick();

    // Save / restore
    set_flags(4'b1001);
    save_req = 1'b1; tick(); save_req = 1'b0;
    chk("sv_shadow", shadow_out, 4'b1001);
    set_flags(4'b0000);
    chk("sv_upd", flag_out, 4'b0000);
    restore_req = 1'b1; upd_valid = 1'b1; upd_s = 1'b1; new_flag = 4'b0110;
    tick();
    restore_req = 1'b0; upd_valid = 1'b0; upd_s = 1'b0;
    chk("rs_flag", flag_out, 4'b1001);
    set_flags(4'b0011);
    save_req = 1'b1; tick(); save_req = 1'b0;
    chk("sv2_shadow", shadow_out, 4'b0011);
    set_flags(4'b0101);
    save_req = 1'b1; restore_req = 1'b1; tick();
    save_req = 1'b0; restore_req = 1'b0;
    chk("sr_flag", flag_out, 4'b0011);
    chk("sr_shadow", shadow_out, 4'b0011);

    // Counter saturation from a clean reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("cnt_clr", squash_cnt, 0);
    set_flags(4'b1111);
    save_req = 1'b1; tick(); save_req = 1'b0;
    cond_valid = 1'b1; cond_code = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("cnt_14", squash_cnt, 14);
      if (i == 15) chk("cnt_15", squash_cnt, 15);
    end
    chk("cnt_sat", squash_cnt, 15);
    chk("pre_valid", res_valid, 1'b1);

    // Asynchronous reset while a result is pending
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_flag", flag_out, 4'h0);
    chk("ar_shadow", shadow_out, 4'h0);
    chk("ar_valid", res_valid, 1'b0);
    chk("ar_pass", res_pass, 1'b0);
    chk("ar_cnt", squash_cnt, 0);
    cond_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
